// File: rtl/lcd_write_sequencer_if.sv
// Purpose : groups the core-side LCD register with the board-side LCD pins and
//           sequencer status of lcd_write_sequencer.
// Latency : n/a (wiring only).
// Backpressure: none; the core polls busy/overrun instead of being stalled.
// Signals : io_lcd      - core LCD register ([7:0] DATA, [8] RS, [9] REQ toggle, [31] ON)
//           lcd_data/rs/rw/en/on - HD44780-style parallel pins
//           busy/init_done/overrun - sequencer status
interface lcd_write_sequencer_if;
  logic [31:0] io_lcd;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic        lcd_on;
  logic        busy;
  logic        init_done;
  logic        overrun;

  // master: the core / register side that drives io_lcd
  modport master (
    output io_lcd,
    input  lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, busy, init_done, overrun
  );

  // slave: the sequencer itself
  modport slave (
    input  io_lcd,
    output lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, busy, init_done, overrun
  );
endinterface

// File: rtl/lcd_write_sequencer.sv
// Purpose : turns toggle-style CPU writes to io_lcd into timed HD44780 write
//           cycles and runs the LCD power-on init sequence by itself.
// Latency : request toggle -> pending at next edge -> SETUP one cycle later when idle;
//           lcd_on follows io_lcd[31] with 1 cycle of latency.
// Backpressure: none upstream; one pending slot, a newer request overwrites it and
//           sets the sticky overrun flag; busy tells the core when to wait.
// Ports   : clk, rst (async, active-low), bus (lcd_write_sequencer_if.slave).
module lcd_write_sequencer #(
  parameter int unsigned PWRUP_CYC     = 750000,
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned EN_CYC        = 16,
  parameter int unsigned HOLD_CYC      = 4,
  parameter int unsigned EXEC_CYC      = 2000,
  parameter int unsigned LONG_EXEC_CYC = 80000
) (
  input  logic                 clk,
  input  logic                 rst,
  lcd_write_sequencer_if.slave bus
);

  // Counter sized for the longest interval so no interval can wrap.
  localparam int unsigned MAX_A   = (PWRUP_CYC > LONG_EXEC_CYC) ? PWRUP_CYC : LONG_EXEC_CYC;
  localparam int unsigned MAX_B   = (EXEC_CYC > EN_CYC) ? EXEC_CYC : EN_CYC;
  localparam int unsigned MAX_C   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_EXEC_CYC - 1);

  localparam logic [2:0] S_PWRUP = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_IDLE  = 3'd2;
  localparam logic [2:0] S_SETUP = 3'd3;
  localparam logic [2:0] S_EN_HI = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_EXEC  = 3'd6;

  // Power-on init list: 8-bit/2-line, display on, clear, entry mode.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_init_idx;
  logic             r_req_prev;
  logic             r_pend_vld;
  logic             r_pend_rs;
  logic [7:0]       r_pend_dat;
  logic [7:0]       r_data;
  logic             r_rs;
  logic             r_en;
  logic             r_on;
  logic             r_busy;
  logic             r_init_done;
  logic             r_overrun;

  logic             w_req;
  logic             w_long_exec;
  logic [CNT_W-1:0] w_cnt_last;
  logic             w_cnt_done;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_idx_nxt;
  logic [7:0]       w_data_nxt;
  logic             w_rs_nxt;
  logic             w_init_done_nxt;
  logic             w_dispatch;
  logic             w_pend_vld_nxt;
  logic             w_pend_rs_nxt;
  logic [7:0]       w_pend_dat_nxt;
  logic             w_overrun_nxt;
  logic             w_unused_io;

  // Only DATA, RS, REQ and ON carry meaning in the core register.
  assign w_unused_io = &{1'b0, bus.io_lcd[30:10]};

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  assign w_long_exec = !r_rs && (r_data[7:2] == 6'd0) && (r_data[1:0] != 2'd0);

  always_comb begin
    case (r_state)
      S_PWRUP: w_cnt_last = PWRUP_LAST;
      S_SETUP: w_cnt_last = SETUP_LAST;
      S_EN_HI: w_cnt_last = EN_LAST;
      S_HOLD:  w_cnt_last = HOLD_LAST;
      S_EXEC:  w_cnt_last = w_long_exec ? LONG_LAST : EXEC_LAST;
      default: w_cnt_last = '0;
    endcase
  end

  assign w_cnt_done = (r_cnt == w_cnt_last);
  assign w_req      = bus.io_lcd[9] ^ r_req_prev;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = w_cnt_done ? '0 : r_cnt + CNT_W'(1);
    w_idx_nxt       = r_init_idx;
    w_data_nxt      = r_data;
    w_rs_nxt        = r_rs;
    w_init_done_nxt = r_init_done;
    w_dispatch      = 1'b0;

    case (r_state)
      S_PWRUP: begin
        if (w_cnt_done) begin
          w_state_nxt = S_SETUP;
          w_idx_nxt   = 2'd0;
          w_data_nxt  = init_cmd(2'd0);
          w_rs_nxt    = 1'b0;
        end
      end
      // Not on the normal path (init commands chain EXEC->SETUP directly);
      // if ever entered it resumes the init list at the current index.
      S_INIT: begin
        w_state_nxt = S_SETUP;
        w_data_nxt  = init_cmd(r_init_idx);
        w_rs_nxt    = 1'b0;
      end
      S_IDLE: begin
        if (r_pend_vld) begin
          w_dispatch  = 1'b1;
          w_state_nxt = S_SETUP;
          w_data_nxt  = r_pend_dat;
          w_rs_nxt    = r_pend_rs;
        end
      end
      S_SETUP: if (w_cnt_done) w_state_nxt = S_EN_HI;
      S_EN_HI: if (w_cnt_done) w_state_nxt = S_HOLD;
      S_HOLD:  if (w_cnt_done) w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (w_cnt_done) begin
          // init_done still clear means we are walking the init list.
          if (!r_init_done && (r_init_idx != 2'd3)) begin
            w_state_nxt = S_SETUP;
            w_idx_nxt   = r_init_idx + 2'd1;
            w_data_nxt  = init_cmd(r_init_idx + 2'd1);
            w_rs_nxt    = 1'b0;
          end else begin
            w_state_nxt     = S_IDLE;
            w_init_done_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_PWRUP;
        w_cnt_nxt   = '0;
      end
    endcase

    // One-deep pending slot; a request arriving in the dispatch cycle refills
    // the freed slot without counting as an overrun.
    w_pend_vld_nxt = r_pend_vld & ~w_dispatch;
    w_pend_rs_nxt  = r_pend_rs;
    w_pend_dat_nxt = r_pend_dat;
    w_overrun_nxt  = r_overrun;
    if (w_req) begin
      if (r_pend_vld && !w_dispatch) w_overrun_nxt = 1'b1;
      w_pend_vld_nxt = 1'b1;
      w_pend_rs_nxt  = bus.io_lcd[8];
      w_pend_dat_nxt = bus.io_lcd[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_PWRUP;
      r_cnt       <= '0;
      r_init_idx  <= 2'd0;
      r_req_prev  <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_rs   <= 1'b0;
      r_pend_dat  <= 8'h00;
      r_data      <= 8'h00;
      r_rs        <= 1'b0;
      r_en        <= 1'b0;
      r_on        <= 1'b0;
      r_busy      <= 1'b1;
      r_init_done <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_init_idx  <= w_idx_nxt;
      r_req_prev  <= bus.io_lcd[9];
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_rs   <= w_pend_rs_nxt;
      r_pend_dat  <= w_pend_dat_nxt;
      r_data      <= w_data_nxt;
      r_rs        <= w_rs_nxt;
      r_en        <= (w_state_nxt == S_EN_HI);
      r_on        <= bus.io_lcd[31];
      r_busy      <= (w_state_nxt != S_IDLE) | w_pend_vld_nxt;
      r_init_done <= w_init_done_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  assign bus.lcd_data  = r_data;
  assign bus.lcd_rs    = r_rs;
  assign bus.lcd_rw    = 1'b0;
  assign bus.lcd_en    = r_en;
  assign bus.lcd_on    = r_on;
  assign bus.busy      = r_busy;
  assign bus.init_done = r_init_done;
  assign bus.overrun   = r_overrun;

endmodule
